// File: rtl/mul_err_pkg.sv
// Shared types and default sizing for the approximate-multiplier error sweep.
// The product and error-count widths follow from the operand width.
package mul_err_pkg;

    localparam int DEF_W        = 8;
    localparam int DEF_PIPE_LAT = 0;
    localparam int DEF_ACC_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Product width PW = 2W.
    function automatic int calc_pw(input int w);
        return 2 * w;
    endfunction

    // Error-count width CW = 2W+1, wide enough to count every operand pair.
    function automatic int calc_cw(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mul_err_accum.sv
// Scores one (exact, approx) product pair per valid cycle: absolute error,
// saturating error sum, nonzero-error count and first-occurrence worst pair.
module mul_err_accum
    import mul_err_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     valid,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    input  logic [calc_pw(W)-1:0]    exact,
    input  logic [calc_pw(W)-1:0]    approx,
    output logic [calc_pw(W)-1:0]    max_err,
    output logic [W-1:0]             worst_a,
    output logic [W-1:0]             worst_b,
    output logic [calc_cw(W)-1:0]    err_cnt,
    output logic [ACC_W-1:0]         sum_abs_err
);

    localparam int PW = calc_pw(W);
    localparam int CW = calc_cw(W);

    logic signed [CW-1:0] w_diff;
    logic [PW-1:0]        w_err;
    logic [ACC_W:0]       w_sum_ext;
    logic [ACC_W-1:0]     w_sum_sat;

    logic [PW-1:0]        r_max;
    logic [W-1:0]         r_wa;
    logic [W-1:0]         r_wb;
    logic [CW-1:0]        r_cnt;
    logic [ACC_W-1:0]     r_sum;

    // NOTE: blocking assignments are right here: each line feeds the next within the same evaluation.
    always_comb begin
        w_diff    = $signed({1'b0, approx}) - $signed({1'b0, exact});
        w_err     = w_diff[CW-1] ? PW'(-w_diff) : PW'(w_diff);
        w_sum_ext = {1'b0, r_sum} + (ACC_W + 1)'(w_err);
        w_sum_sat = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_wa  <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
            r_sum <= '0;
        end else if (clear) begin
            r_max <= '0;
            r_wa  <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
            r_sum <= '0;
        end else if (valid) begin
            r_sum <= w_sum_sat;
            if (w_err != '0) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Strictly greater keeps the first pair that reached the maximum.
            if (w_err > r_max) begin
                r_max <= w_err;
                r_wa  <= a;
                r_wb  <= b;
            end
        end
    end

    assign max_err     = r_max;
    assign worst_a     = r_wa;
    assign worst_b     = r_wb;
    assign err_cnt     = r_cnt;
    assign sum_abs_err = r_sum;

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Sweeps every operand pair through an external approximate multiplier and
// scores its product against the exact one, aligned by a PIPE_LAT-deep pipeline.
module mul_err_sweep_ctrl
    import mul_err_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [W-1:0]             op_a,
    output logic [W-1:0]             op_b,
    input  logic [calc_pw(W)-1:0]    approx_p,
    output logic                     busy,
    output logic                     done,
    output logic [calc_pw(W)-1:0]    max_err,
    output logic [W-1:0]             worst_a,
    output logic [W-1:0]             worst_b,
    output logic [calc_cw(W)-1:0]    err_cnt,
    output logic [ACC_W-1:0]         sum_abs_err
);

    localparam int            PW       = calc_pw(W);
    localparam int            DCW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [PW-1:0] LAST_IDX = '1;

    state_t         r_state;
    logic [PW-1:0]  r_idx;
    logic           r_busy;
    logic           r_done;
    logic [DCW-1:0] r_drain_cnt;

    logic           w_start_ok;
    logic           w_abort;
    logic           w_v0;
    logic [PW-1:0]  w_exact0;
    logic           w_v_out;
    logic [PW-1:0]  w_idx_out;
    logic [PW-1:0]  w_exact_out;

    assign w_start_ok = (r_state == IDLE) && start && !abort;
    assign w_abort    = abort && ((r_state == RUN) || (r_state == DRAIN));

    // r_idx is zero outside RUN and wraps to zero after the last pair, so it drives the operands directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state; the default clear makes done a one-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state <= RUN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            if (PIPE_LAT > 0) begin
                                r_state     <= DRAIN;
                                r_drain_cnt <= DCW'(PIPE_LAT - 1);
                            end else begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign op_a = r_idx[PW-1:W];
    assign op_b = r_idx[W-1:0];
    assign busy = r_busy;
    assign done = r_done;

    assign w_v0     = (r_state == RUN);
    assign w_exact0 = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign w_v_out     = w_v0;
            assign w_idx_out   = r_idx;
            assign w_exact_out = w_exact0;
        end else begin : g_pipe
            logic          r_pv     [PIPE_LAT];
            logic [PW-1:0] r_pidx   [PIPE_LAT];
            logic [PW-1:0] r_pexact [PIPE_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) r_pv[i] <= 1'b0;
                end else if (w_abort) begin
                    for (int i = 0; i < PIPE_LAT; i++) r_pv[i] <= 1'b0;
                end else begin
                    r_pv[0] <= w_v0;
                    for (int i = 1; i < PIPE_LAT; i++) r_pv[i] <= r_pv[i-1];
                end
            end

            // NOTE: the data stages are deliberately not reset; they are only consumed when the matching valid bit is set.
            always_ff @(posedge clk) begin
                r_pidx[0]   <= r_idx;
                r_pexact[0] <= w_exact0;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    r_pidx[i]   <= r_pidx[i-1];
                    r_pexact[i] <= r_pexact[i-1];
                end
            end

            assign w_v_out     = r_pv[PIPE_LAT-1];
            assign w_idx_out   = r_pidx[PIPE_LAT-1];
            assign w_exact_out = r_pexact[PIPE_LAT-1];
        end
    endgenerate

    mul_err_accum #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (w_start_ok),
        .valid       (w_v_out),
        .a           (w_idx_out[PW-1:W]),
        .b           (w_idx_out[W-1:0]),
        .exact       (w_exact_out),
        .approx      (approx_p),
        .max_err     (max_err),
        .worst_a     (worst_a),
        .worst_b     (worst_b),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err)
    );

endmodule
